// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the SRAM initiator: FSM state encoding,
// wait-counter width and the word-alignment mask.
// Latency: n/a (package). Backpressure: n/a.
package sram_ctrl_pkg;

    // Width of the access-phase wait counter (WAIT values 1..15).
    localparam int CNT_W = 4;

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Bundle of the CPU request/response channel and the SRAM pin interface.
// Latency: n/a (wires only). Backpressure: req_ready only; responses cannot be stalled.
// Modports: slave = the controller; master = CPU requester plus SRAM model.
interface sram_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    // response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // SRAM pins
    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, sram_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               sram_cs, sram_oe, sram_we, sram_addr, sram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               sram_cs, sram_oe, sram_we, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter timing the SRAM access phase; o_last marks the final cycle.
// Latency: load takes effect on the next edge. Backpressure: none.
// Ports: clk/reset, i_load + i_load_val, i_dec (count enable), o_last.
module sram_wait_cnt
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Treat 0 as "last" too, so an out-of-range load can never wedge the FSM.
    assign o_last = (r_cnt[CNT_W-1:1] == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous initiator for an asynchronous SRAM: setup / access / hold strobe sequencing.
// Latency: rsp_valid in the cycle closing 2+WAIT edges after accept; one request per 3+WAIT cycles.
// Backpressure: req_ready only in IDLE (and not in reset); rsp_valid cannot be stalled.
// Ports: clk, reset (sync, active-high), bus (sram_ctrl_if.slave: req_*, rsp_*, sram_*).
// Optional: define SRAM_CTRL_ALIGN_CHECK_EN to reject requests with req_addr[1:0] != 0.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    sram_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT);

    state_t            r_state;
    state_t            w_state_nxt;

    // latched request and registered SRAM pins
    logic              r_we;
    logic              r_sram_cs;
    logic              r_sram_oe;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_din;
    logic              r_rsp_vld;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_misaligned;
    logic              w_cs_nxt;
    logic              w_oe_nxt;
    logic              w_we_nxt;
    logic              w_rsp_vld_nxt;
    logic              w_latch;
    logic              w_capture;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_cnt_last;

    assign w_req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept    = bus.req_valid && w_req_ready;

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(bus.req_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    sram_wait_cnt u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_latch),
        .i_load_val (w_load_val),
        .i_dec      (r_state == S_ACCESS),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-pin values; pins are registered so nothing on
    // req_* reaches the SRAM combinationally.
    always_comb begin
        w_state_nxt   = r_state;
        w_cs_nxt      = r_sram_cs;
        w_oe_nxt      = 1'b0;
        w_we_nxt      = 1'b0;
        w_rsp_vld_nxt = 1'b0;
        w_latch       = 1'b0;
        w_capture     = 1'b0;
        w_load_val    = bus.req_we ? WR_LOAD : RD_LOAD;
        case (r_state)
            S_IDLE: begin
                w_cs_nxt = 1'b0;
                if (w_accept) begin
                    if (w_misaligned) begin
                        // rejected: straight to the response cycle, pins untouched
                        w_state_nxt   = S_HOLD;
                        w_rsp_vld_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_cs_nxt    = 1'b1;
                        w_latch     = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
                w_oe_nxt    = !r_we;
                w_we_nxt    = r_we;
            end
            S_ACCESS: begin
                if (w_cnt_last) begin
                    // closing edge of the strobe: capture read data here
                    w_state_nxt   = S_HOLD;
                    w_rsp_vld_nxt = 1'b1;
                    w_capture     = !r_we;
                end else begin
                    w_oe_nxt = !r_we;
                    w_we_nxt = r_we;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
                w_cs_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cs_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_sram_cs   <= 1'b0;
            r_sram_oe   <= 1'b0;
            r_sram_we   <= 1'b0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_sram_cs <= w_cs_nxt;
            r_sram_oe <= w_oe_nxt;
            r_sram_we <= w_we_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
            // addr/din only move while cs is low, keeping them stable across cs=1
            if (w_latch) begin
                r_we        <= bus.req_we;
                r_sram_addr <= bus.req_addr;
                r_sram_din  <= bus.req_wdata;
            end
            if (w_capture) begin
                r_rsp_rdata <= bus.sram_dout;
            end
        end
    end

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    logic r_rsp_err;
    logic w_err_nxt;

    assign w_err_nxt = (r_state == S_IDLE) && w_accept && w_misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_err_nxt;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.sram_cs   = r_sram_cs;
    assign bus.sram_oe   = r_sram_oe;
    assign bus.sram_we   = r_sram_we;
    assign bus.sram_addr = r_sram_addr;
    assign bus.sram_din  = r_sram_din;

endmodule
